coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_pkg.sv | 46 ++++
 rtl/coin_sync.sv | 23 ++
 rtl/coin_acceptor.sv | 143 ++++++++++++++
 tb/tb_coin_acceptor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared types, coin values and counter helpers for the coin acceptor
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    HOLD,
    ISSUE,
    RELEASE,
    LOCKOUT
  } state_t;

  typedef enum logic [2:0] {
    NONE,
    NICKEL,
    DIME,
    QUARTER,
    DOLLAR
  } coin_t;

  localparam int unsigned NICKEL_CENTS  = 5;
  localparam int unsigned DIME_CENTS    = 10;
  localparam int unsigned QUARTER_CENTS = 25;
  localparam int unsigned DOLLAR_CENTS  = 100;

  // Line pattern order is {dollar, quarter, dime, nickel}; anything but one hot is NONE.
  function automatic coin_t decode_coin(input logic [3:0] pattern);
    case (pattern)
      4'b0001: return NICKEL;
      4'b0010: return DIME;
      4'b0100: return QUARTER;
      4'b1000: return DOLLAR;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // True on the cycle that completes `limit` counted cycles (count starts at 0).
  function automatic logic reached(input logic [15:0] cnt, input int unsigned limit);
    return (32'(cnt) + 32'd1) >= limit;
  endfunction

endpackage

// File: rtl/coin_sync.sv
// rtl/coin_sync.sv - parameterized-width two-flop synchronizer with asynchronous reset
module coin_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin slot front end issuing one credit or reject per coin
// Define COIN_JAM_DETECT_EN to enable the sticky slot-jam flag.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned JAM_CYCLES      = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_nickel,
  input  logic raw_dime,
  input  logic raw_quarter,
  input  logic raw_dollar,
  input  logic nickel_full,
  input  logic dime_full,
  input  logic quarter_full,
  input  logic dollar_full,
  input  logic busy,
  output logic nickel,
  output logic dime,
  output logic quarter,
  output logic dollar,
  output logic coin_reject,
  output logic jam
);

  state_t      state;
  logic [15:0] count;
  logic [3:0]  pattern;
  logic [3:0]  lines;
  coin_t       coin;
  logic        stack_full;
  logic        jammed;

  coin_sync #(.WIDTH(4)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in ({raw_dollar, raw_quarter, raw_dime, raw_nickel}),
    .sync_out (lines)
  );

  assign coin = decode_coin(pattern);

  always_comb begin
    stack_full = 1'b1;
    case (coin)
      NICKEL:  stack_full = nickel_full;
      DIME:    stack_full = dime_full;
      QUARTER: stack_full = quarter_full;
      DOLLAR:  stack_full = dollar_full;
      default: stack_full = 1'b1;
    endcase
  end

`ifdef COIN_JAM_DETECT_EN
  logic [15:0] jam_count;

  assign jammed = jam | reached(jam_count, JAM_CYCLES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jam       <= 1'b0;
      jam_count <= '0;
    end else if (state == RELEASE) begin
      jam_count <= sat_inc(jam_count);
      if (jammed) jam <= 1'b1;
    end else begin
      jam_count <= '0;
    end
  end
`else
  // No jam detection: the flag is constant low and JAM_CYCLES has no effect.
  assign jammed = 1'b0;
  assign jam    = (JAM_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      pattern     <= '0;
      nickel      <= 1'b0;
      dime        <= 1'b0;
      quarter     <= 1'b0;
      dollar      <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      nickel      <= 1'b0;
      dime        <= 1'b0;
      quarter     <= 1'b0;
      dollar      <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (|lines) begin
            state   <= QUALIFY;
            pattern <= lines;
            count   <= '0;
          end
        end
        QUALIFY: begin
          // A change in the pattern wins over completing the count on the same cycle.
          if (lines != pattern)                    state <= IDLE;
          else if (reached(count, DEBOUNCE_CYCLES)) state <= busy ? HOLD : ISSUE;
          else                                      count <= sat_inc(count);
        end
        HOLD: begin
          if (!busy) state <= ISSUE;
        end
        ISSUE: begin
          if (stack_full) begin
            coin_reject <= 1'b1;
          end else begin
            nickel  <= (coin == NICKEL);
            dime    <= (coin == DIME);
            quarter <= (coin == QUARTER);
            dollar  <= (coin == DOLLAR);
          end
          state <= RELEASE;
          count <= '0;
        end
        RELEASE: begin
          if (|lines) begin
            count <= '0;
          end else if (!jammed && reached(count, DEBOUNCE_CYCLES)) begin
            state <= LOCKOUT;
            count <= '0;
          end else begin
            count <= sat_inc(count);
          end
        end
        LOCKOUT: begin
          if (reached(count, LOCKOUT_CYCLES)) state <= IDLE;
          else                                count <= sat_inc(count);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - randomized coin insertions checked every cycle against a timing model
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int D = 4;
  localparam int L = 8;
  localparam int J = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic raw_nickel = 1'b0, raw_dime = 1'b0, raw_quarter = 1'b0, raw_dollar = 1'b0;
  logic nickel_full = 1'b0, dime_full = 1'b0, quarter_full = 1'b0, dollar_full = 1'b0;
  logic busy = 1'b0;
  logic nickel, dime, quarter, dollar, coin_reject, jam;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .JAM_CYCLES(J)) dut (
    .clock(clock), .reset(reset),
    .raw_nickel(raw_nickel), .raw_dime(raw_dime), .raw_quarter(raw_quarter), .raw_dollar(raw_dollar),
    .nickel_full(nickel_full), .dime_full(dime_full), .quarter_full(quarter_full), .dollar_full(dollar_full),
    .busy(busy),
    .nickel(nickel), .dime(dime), .quarter(quarter), .dollar(dollar),
    .coin_reject(coin_reject), .jam(jam)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [4:0] exp_pulse [int];
  int jam_edge = -1;
  bit jam_arm = 1'b0;
  int busy_end = 0;
  int exp_count = 0, exp_cents = 0;
  int pulse_count = 0, seen_cents = 0, last_pulse_cyc = -1;
  logic [4:0] last_pulse_vec = 5'b0;
  logic [4:0] act_vec, exp_vec;
  logic exp_jam;

  function automatic int cents_of(input logic [4:0] vec);
    case (vec)
      5'b10000: return NICKEL_CENTS;
      5'b01000: return DIME_CENTS;
      5'b00100: return QUARTER_CENTS;
      5'b00010: return DOLLAR_CENTS;
      default:  return 0;
    endcase
  endfunction

  always @(negedge clock) begin
    act_vec = {nickel, dime, quarter, dollar, coin_reject};
    exp_vec = exp_pulse.exists(cyc) ? exp_pulse[cyc] : 5'b0;
    exp_jam = !reset && jam_edge >= 0 && cyc >= jam_edge;
    checks++;
    if (act_vec !== exp_vec || jam !== exp_jam) begin
      errors++;
      $display("FAIL outputs edge %0d: got pulses=%b jam=%b, expected pulses=%b jam=%b",
               cyc, act_vec, jam, exp_vec, exp_jam);
    end
    if (act_vec != 5'b0) begin
      pulse_count++;
      last_pulse_cyc = cyc;
      last_pulse_vec = act_vec;
      seen_cents += cents_of(act_vec);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    busy = (cyc + 1 < busy_end);
  endtask

  task automatic set_raw(input logic [3:0] p);
    {raw_dollar, raw_quarter, raw_dime, raw_nickel} = p;
  endtask

  // The coin is taken as rising on the first edge of its final stable segment (r); it
  // qualifies D+2 edges later, waits there while busy is sampled high, and pulses one edge on.
  task automatic run_coin(input logic [3:0] p, input int n_bounce, input int blen,
                          input int hold_len, input int busy_len, input logic [3:0] full,
                          output int r, output int pulse);
    int len;
    logic [3:0] bp;
    logic [4:0] vec;
    {dollar_full, quarter_full, dime_full, nickel_full} = full;
    busy_end = cyc + 1 + busy_len;
    busy = (cyc + 1 < busy_end);
    for (int b = 0; b < n_bounce; b++) begin
      len = (blen > 0) ? blen : int'($urandom_range(D, 1));
      bp  = (blen > 0) ? p : 4'($urandom_range(15, 1));
      set_raw(bp);
      repeat (len) step();
      set_raw(4'b0);
      len = (blen > 0) ? blen : int'($urandom_range(3, 1));
      repeat (len) step();
    end
    r = cyc + 1;
    pulse = ((r + D + 2 > busy_end) ? r + D + 2 : busy_end) + 1;
    vec = ($countones(p) == 1 && (p & full) == 4'b0) ? {p[0], p[1], p[2], p[3], 1'b0} : 5'b00001;
    exp_pulse[pulse] = vec;
    exp_count++;
    exp_cents += cents_of(vec);
    if (jam_arm) jam_edge = pulse + J;
    set_raw(p);
    repeat (hold_len) step();
    set_raw(4'b0);
    while (cyc < pulse) step();
    repeat (40) step();
  endtask

  int r, pulse, n;
  logic [3:0] p;

  initial begin
    repeat (3) step();
    check("reset_outputs", int'({nickel, dime, quarter, dollar, coin_reject, jam}), 0);
    reset = 1'b0;
    repeat (5) step();

    run_coin(4'b0010, 0, 0, 20, 0, 4'b0000, r, pulse);
    check("dime_latency", last_pulse_cyc - r, 7);
    check("dime_vec", int'(last_pulse_vec), 5'b01000);

    n = pulse_count;
    run_coin(4'b0001, 2, 2, 12, 0, 4'b0000, r, pulse);
    check("nickel_bounce_count", pulse_count - n, 1);
    check("nickel_bounce_latency", last_pulse_cyc - r, 7);

    run_coin(4'b1100, 0, 0, 10, 0, 4'b0000, r, pulse);
    check("multi_reject", int'(last_pulse_vec), 5'b00001);

    run_coin(4'b0100, 0, 0, 10, 0, 4'b0100, r, pulse);
    check("quarter_full_reject", int'(last_pulse_vec), 5'b00001);
    run_coin(4'b0100, 0, 0, 10, 0, 4'b0000, r, pulse);
    check("quarter_accept", int'(last_pulse_vec), 5'b00100);

    run_coin(4'b1000, 0, 0, 20, 30, 4'b0000, r, pulse);
    check("dollar_after_busy", last_pulse_cyc, busy_end + 1);
    check("dollar_vec", int'(last_pulse_vec), 5'b00010);

    // Reset while the dollar waits on busy: the pending coin must vanish.
    n = pulse_count;
    busy_end = cyc + 101;
    busy = 1'b1;
    set_raw(4'b1000);
    repeat (D + 8) step();
    reset = 1'b1;
    set_raw(4'b0);
    #1;
    check("reset_async_outputs", int'({nickel, dime, quarter, dollar, coin_reject, jam}), 0);
    step();
    step();
    busy_end = 0;
    busy = 1'b0;
    reset = 1'b0;
    repeat (60) step();
    check("reset_discard", pulse_count - n, 0);

    for (int t = 0; t < 40; t++) begin
      p = ($urandom_range(1, 0) == 1) ? 4'(1 << $urandom_range(3, 0)) : 4'($urandom_range(15, 1));
      run_coin(p, int'($urandom_range(3, 0)), 0, int'($urandom_range(60, D + 1)),
               int'($urandom_range(25, 0)), 4'($urandom_range(15, 0)), r, pulse);
    end
    {dollar_full, quarter_full, dime_full, nickel_full} = 4'b0000;

`ifdef COIN_JAM_DETECT_EN
    jam_arm = 1'b1;
    n = pulse_count;
    run_coin(4'b0001, 0, 0, 1100, 0, 4'b0000, r, pulse);
    jam_arm = 1'b0;
    check("jam_single_pulse", pulse_count - n, 1);
    check("jam_set", int'(jam), 1);
    repeat (50) step();
    check("jam_sticky", int'(jam), 1);
    reset = 1'b1;
    jam_edge = -1;
    #1;
    check("jam_cleared", int'(jam), 0);
    step();
    reset = 1'b0;
    repeat (5) step();
`endif

    check("pulse_total", pulse_count, exp_count);
    check("cents_total", seen_cents, exp_cents);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
